muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Multi-cycle multiply/divide unit owning the architectural HI/LO registers, sitting beside the ALU in the EX stage of the MIPS pipeline. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and presents HI/LO for MFHI/MFLO. It raises a stall to the pipeline while a 32-iteration division is in flight.

## Interface
- No parameters. Opcodes are the `EXE_*_OP` codes from defines.vh: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- clk  in  1  sole clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start_i  in  1  EX holds a valid instruction; op_i, num1_i and num2_i are valid.
- op_i  in  8  ALU control code of the EX instruction; codes not listed above are ignored.
- num1_i  in  32  rs value (dividend/multiplicand; source for MTHI/MTLO).
- num2_i  in  32  rt value (divisor/multiplier).
- flush_i  in  1  exception/ERET flush; cancels any in-flight operation.
- ex_stall_i  in  1  downstream stall; holds the unit in DONE.
- stall_o  out  1  stall request to the hazard unit.
- hi_o  out  32  registered HI.
- lo_o  out  32  registered LO.

## Operation
- Reset: HI=0, LO=0, state=IDLE, counter=0, stall_o=0.
- States: IDLE, DIV, DONE.
- IDLE, start_i=1, flush_i=0:
  - MULT: {HI,LO} <= signed 64-bit num1_i*num2_i at this edge; no stall.
  - MULTU: {HI,LO} <= unsigned product at this edge; no stall.
  - MTHI: HI <= num1_i. MTLO: LO <= num1_i. Single cycle, no stall.
  - DIV/DIVU with num2_i != 0: latch operands and sign info, counter <= 0, go to DIV. stall_o=1 combinationally in this cycle.
  - DIV/DIVU with num2_i == 0: no-op. HI/LO unchanged, no stall, stay in IDLE.
- DIV: restoring radix-2, one quotient bit per cycle on the 32-bit magnitudes. Uses a 33-bit partial-remainder subtract. counter increments each cycle; after the counter=31 iteration, go to DONE. stall_o=1 throughout.
- DONE: stall_o=0. HI <= remainder, LO <= quotient at the edge leaving DONE.
  - Stay in DONE while ex_stall_i=1; HI/LO are rewritten with the same values each cycle.
  - Return to IDLE when ex_stall_i=0.
  - start_i is ignored in DONE.
- Signed (DIV) results:
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- DIVU treats operands as unsigned.
- flush_i=1 in any state: next state IDLE, counter=0, no HI/LO write that cycle. flush_i has priority over start_i.
- Multiply and MT ops in IDLE write even when ex_stall_i=1. This is safe because a held instruction rewrites identical values.

## Timing
- MULT/MULTU/MTHI/MTLO: hi_o/lo_o show the new value in the cycle after the start edge.
- DIV/DIVU: stall_o high for 33 cycles (start cycle plus 32 DIV cycles), then low in DONE.
- HI/LO are valid in the cycle after DONE. Total latency is 34 cycles from start to visible result, with no ex_stall_i.
- Back-to-back divides: the second start_i is sampled in IDLE the cycle after DONE.
- An MFHI/MFLO in EX in the same cycle as a preceding MULT/MTHI write sees the old value. Forwarding is the pipeline's responsibility.
- resetn asserted mid-division: immediate IDLE, HI=LO=0, stall_o=0 while reset is held.
- stall_o depends combinationally on state, start_i, op_i, num2_i and flush_i; it has no dependence on its own output.

## Test plan
- Reset then MTHI 0x12345678, MTLO 0x9ABCDEF0 -> hi_o=0x12345678, lo_o=0x9ABCDEF0 one cycle later, stall_o never high.
- MULT 0xFFFFFFFF*0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV -7/2 -> stall_o high exactly 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFD; DIVU 100/7 -> HI=2, LO=14.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU x/0 with HI/LO preset -> unchanged, no stall.
- DIVU 100/7 with flush_i at DIV cycle 10 -> IDLE next cycle, stall_o=0, HI/LO keep prior values. A following DIVU 9/4 -> HI=1, LO=2.
- DIVU 9/4 with ex_stall_i held 3 cycles in DONE -> stays in DONE, no restart, stall_o=0. Afterwards a new DIVU 8/2 starts cleanly -> LO=4, HI=0.

Source files
------------

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multiply/divide unit that owns the architectural HI/LO
// registers in the EX stage of the MIPS pipeline.
//
// The unit executes MULT, MULTU, MTHI and MTLO in a single cycle. It runs
// DIV and DIVU as a 32-iteration restoring divider and holds the pipeline
// with stall_o while the divide is in flight.
//
// Ports:
//   clk         in   1   sole clock, rising edge
//   resetn      in   1   asynchronous active-low reset
//   start_i     in   1   EX holds a valid instruction (op/num1/num2 valid)
//   op_i        in   8   ALU control code; unknown codes are ignored
//   num1_i      in  32   rs: dividend / multiplicand / MTHI-MTLO source
//   num2_i      in  32   rt: divisor / multiplier
//   flush_i     in   1   exception/ERET flush, cancels in-flight work
//   ex_stall_i  in   1   downstream stall, holds the unit in DONE
//   stall_o     out  1   stall request to the hazard unit
//   hi_o        out 32   registered HI
//   lo_o        out 32   registered LO
module muldiv_hilo (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [7:0]  op_i,
  input  logic [31:0] num1_i,
  input  logic [31:0] num2_i,
  input  logic        flush_i,
  input  logic        ex_stall_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // ALU control codes, matching EXE_*_OP in defines.vh
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rem_q, rem_d;       // partial remainder (magnitude)
  logic [31:0] quo_q, quo_d;       // dividend shifts out the top, quotient shifts in the bottom
  logic [31:0] dvs_q, dvs_d;       // divisor magnitude
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  // Decode of the EX instruction
  logic        is_div, is_signed_div, div_start;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod_s, prod_u;

  // One restoring iteration
  logic [32:0] shifted;
  logic [32:0] sub;
  logic        ge;
  logic [31:0] quo_res, rem_res;

  always_comb begin
    is_div        = (op_i == EXE_DIV_OP) || (op_i == EXE_DIVU_OP);
    is_signed_div = (op_i == EXE_DIV_OP);
    div_start     = start_i && is_div && (num2_i != 32'd0);
    a_neg         = is_signed_div && num1_i[31];
    b_neg         = is_signed_div && num2_i[31];
    a_mag         = a_neg ? (32'd0 - num1_i) : num1_i;
    b_mag         = b_neg ? (32'd0 - num2_i) : num2_i;

    prod_s = $signed({{32{num1_i[31]}}, num1_i}) * $signed({{32{num2_i[31]}}, num2_i});
    prod_u = {32'd0, num1_i} * {32'd0, num2_i};

    shifted = {rem_q, quo_q[31]};
    sub     = shifted - {1'b0, dvs_q};
    // The remainder is always below the divisor. A set top bit in shifted
    // therefore guarantees the subtract fits. Otherwise sub[32] is the
    // borrow.
    ge      = shifted[32] || !sub[32];

    // 0x80000000 / -1 works out naturally: the magnitude is 0x80000000 and
    // negating it wraps back to 0x80000000.
    quo_res = neg_quo_q ? (32'd0 - quo_q) : quo_q;
    rem_res = neg_rem_q ? (32'd0 - rem_q) : rem_q;
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          unique case (op_i)
            EXE_MULT_OP:  {hi_d, lo_d} = prod_s;
            EXE_MULTU_OP: {hi_d, lo_d} = prod_u;
            EXE_MTHI_OP:  hi_d = num1_i;
            EXE_MTLO_OP:  lo_d = num1_i;
            default: ;
          endcase
        end
        if (div_start) begin
          state_d   = S_DIV;
          cnt_d     = 5'd0;
          rem_d     = 32'd0;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
        end
      end
      S_DIV: begin
        rem_d = ge ? sub[31:0] : shifted[31:0];
        quo_d = {quo_q[30:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Rewritten every cycle while held, so a stalled result is stable.
        hi_d = rem_res;
        lo_d = quo_res;
        if (!ex_stall_i) begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase

    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Stall covers the start cycle of a real divide and every DIV cycle.
  always_comb begin
    stall_o = !flush_i &&
              ((state_q == S_DIV) || ((state_q == S_IDLE) && div_start));
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;

  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  op_i = 8'd0;
  logic [31:0] num1_i = 32'd0;
  logic [31:0] num2_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        ex_stall_i = 1'b0;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_hilo dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (start_i),
    .op_i       (op_i),
    .num1_i     (num1_i),
    .num2_i     (num2_i),
    .flush_i    (flush_i),
    .ex_stall_i (ex_stall_i),
    .stall_o    (stall_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stl;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one instruction and wait for its result. The instruction is issued
  // at the next edge after the task is entered, and start_i is dropped after
  // that edge. The task counts stall cycles and then checks the stall count
  // and HI/LO.
  task automatic run_op(input string nm, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int es);
    int cnt;
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; num1_i = a; num2_i = b;
    @(negedge clk);
    cnt = stall_o ? 1 : 0;
    @(posedge clk); #1;
    start_i = 1'b0;
    if (cnt != 0) begin
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (stall_o) cnt++;
        else break;
      end
      @(posedge clk); #1;   // edge leaving DONE writes HI/LO
    end
    chk({nm, "_stall"}, cnt, es);
    chk({nm, "_hi"}, hi_o, eh);
    chk({nm, "_lo"}, lo_o, el);
    $display("op %-10s a=%08h b=%08h -> hi=%08h lo=%08h stall=%0d", nm, a, b, hi_o, lo_o, cnt);
  endtask

  initial begin
    vecs[0]  = '{"mthi",     OP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
    vecs[1]  = '{"mtlo",     OP_MTLO,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
    vecs[2]  = '{"mult",     OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 0};
    vecs[3]  = '{"multu",    OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 0};
    vecs[4]  = '{"div_m7_2", OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[5]  = '{"divu_100", OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[6]  = '{"div_ovf",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[7]  = '{"div_7_m2", OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[8]  = '{"divu_max", OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
    vecs[9]  = '{"divu_z",   OP_DIVU,  32'h00001234, 32'h0,        32'h0000000F, 32'h0FFFFFFF, 0};
    vecs[10] = '{"div_z",    OP_DIV,   32'd5,        32'h0,        32'h0000000F, 32'h0FFFFFFF, 0};
    vecs[11] = '{"mult_min", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0};
    vecs[12] = '{"divu_5_9", OP_DIVU,  32'd5,        32'd9,        32'd5,        32'd0,        33};
    vecs[13] = '{"bad_op",   8'hFF,    32'h11111111, 32'h22222222, 32'd5,        32'd0,        0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    $display("reset: hi=%08h lo=%08h stall=%0b", hi_o, lo_o, stall_o);
    resetn = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].stl);

    // Flush at DIV cycle 10 cancels the divide. HI/LO keep their prior values.
    run_op("pre_hi", OP_MTHI, 32'hAAAA0000, 32'd0, 32'hAAAA0000, 32'd0, 0);
    run_op("pre_lo", OP_MTLO, 32'h00005555, 32'd0, 32'hAAAA0000, 32'h00005555, 0);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = OP_DIVU; num1_i = 32'd100; num2_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("flush_stall0", {31'd0, stall_o}, 32'd0);
    chk("flush_hi", hi_o, 32'hAAAA0000);
    chk("flush_lo", lo_o, 32'h00005555);
    @(negedge clk);
    chk("flush_stall1", {31'd0, stall_o}, 32'd0);
    $display("flush: stall=%0b hi=%08h lo=%08h", stall_o, hi_o, lo_o);
    run_op("divu_9_4", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 33);

    // ex_stall_i holds the unit in DONE. A start_i in DONE is ignored.
    begin
      int cnt;
      @(posedge clk); #1;
      start_i = 1'b1; op_i = OP_DIVU; num1_i = 32'd9; num2_i = 32'd4; ex_stall_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (stall_o) cnt++;
        else break;
      end
      chk("hold_stall_cnt", cnt, 33);
      for (int k = 0; k < 3; k++) begin
        start_i = 1'b1; op_i = OP_DIVU; num1_i = 32'd8; num2_i = 32'd2;
        @(negedge clk);
        chk("hold_stall", {31'd0, stall_o}, 32'd0);
        chk("hold_hi", hi_o, 32'd1);
        chk("hold_lo", lo_o, 32'd2);
        $display("hold %0d: stall=%0b hi=%08h lo=%08h", k, stall_o, hi_o, lo_o);
      end
      start_i = 1'b0; ex_stall_i = 1'b0;
      @(negedge clk);
      chk("rel_stall", {31'd0, stall_o}, 32'd0);
      chk("rel_hi", hi_o, 32'd1);
      chk("rel_lo", lo_o, 32'd2);
    end
    run_op("divu_8_2", OP_DIVU, 32'd8, 32'd2, 32'd0, 32'd4, 33);

    // Asserting reset mid-division returns the unit to IDLE with HI/LO cleared.
    run_op("mthi_dead", OP_MTHI, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'd4, 0);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = OP_DIVU; num1_i = 32'd50; num2_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid_rst_hi", hi_o, 32'd0);
    chk("mid_rst_lo", lo_o, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    $display("mid-div reset: hi=%08h lo=%08h stall=%0b", hi_o, lo_o, stall_o);
    @(negedge clk);
    resetn = 1'b1;
    run_op("multu_3_5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
